// File: rtl/reg_arb_pkg.sv
// Shared types and default sizes for the register-bank write arbiter.
// The bank is 2**ADDR_W registers of WIDTH bits, shared by N_REQ sources.
package reg_arb_pkg;
  localparam int N_REQ  = 4;
  localparam int WIDTH  = 16;
  localparam int ADDR_W = 3;
  localparam int IDX_W  = $clog2(N_REQ);

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [WIDTH-1:0]  reg_data_t;
endpackage

// File: rtl/reg_wr_arbiter_if.sv
// Requester handshake plus registered write port into the register bank.
// master = requesters/bank side, slave = arbiter.
interface reg_wr_arbiter_if
  import reg_arb_pkg::*;
#(
  parameter int N_REQ  = reg_arb_pkg::N_REQ,
  parameter int WIDTH  = reg_arb_pkg::WIDTH,
  parameter int ADDR_W = reg_arb_pkg::ADDR_W
);
  localparam int IW = $clog2(N_REQ);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*WIDTH-1:0]  req_data;
  logic [N_REQ-1:0]        req_ready;
  logic                    hold;
  logic                    wr_en;
  logic [ADDR_W-1:0]       wr_addr;
  logic [WIDTH-1:0]        wr_data;
  logic [IW-1:0]           grant_idx;

  modport master (
    output req_valid, req_addr, req_data, hold,
    input  req_ready, wr_en, wr_addr, wr_data, grant_idx
  );

  modport slave (
    input  req_valid, req_addr, req_data, hold,
    output req_ready, wr_en, wr_addr, wr_data, grant_idx
  );
endinterface

// File: rtl/reg_wr_arbiter_rr_select.sv
// Round-robin pick: first valid at or above ptr, wrapping mod N_REQ.
module rr_select
  import reg_arb_pkg::*;
#(
  parameter int N_REQ = reg_arb_pkg::N_REQ,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    idx,
  output logic             any_valid
);
  always_comb begin
    int  j;
    logic found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(ptr) + k) % N_REQ;
      if (!found && valid[j]) begin
        grant[j] = 1'b1;
        idx      = IW'(j);
        found    = 1'b1;
      end
    end
  end

  assign any_valid = |valid;
endmodule

// File: rtl/reg_wr_arbiter.sv
// Shares one register-bank write port among N_REQ sources, round-robin,
// one accepted write per cycle, registered toward the bank.
module reg_wr_arbiter
  import reg_arb_pkg::*;
#(
  parameter int N_REQ  = reg_arb_pkg::N_REQ,
  parameter int WIDTH  = reg_arb_pkg::WIDTH,
  parameter int ADDR_W = reg_arb_pkg::ADDR_W
) (
  input logic           clk,
  input logic           rst,
  reg_wr_arbiter_if.slave bus
);
  localparam int IW = $clog2(N_REQ);

  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0]  wr_data_q, wr_data_d;
  logic [IW-1:0]     grant_idx_q, grant_idx_d;

  logic [N_REQ-1:0] gnt;
  logic [IW-1:0]    win;
  logic             any_valid;

  rr_select #(.N_REQ(N_REQ), .IW(IW)) u_sel (
    .valid     (bus.req_valid),
    .ptr       (rr_ptr_q),
    .grant     (gnt),
    .idx       (win),
    .any_valid (any_valid)
  );

  assign bus.req_ready = (rst || bus.hold) ? '0 : gnt;

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    wr_en_d     = wr_en_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    grant_idx_d = grant_idx_q;
    // hold freezes every register, wr_en included
    if (!bus.hold) begin
      wr_en_d = any_valid;
      if (any_valid) begin
        grant_idx_d = win;
        rr_ptr_d = (win == IW'(N_REQ - 1)) ? '0
                 : win + IW'(1);
        for (int i = 0; i < N_REQ; i++) begin
          if (gnt[i]) begin
            wr_addr_d = bus.req_addr[i*ADDR_W +: ADDR_W];
            wr_data_d = bus.req_data[i*WIDTH +: WIDTH];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      grant_idx_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      grant_idx_q <= grant_idx_d;
    end
  end

  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.grant_idx = grant_idx_q;
endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Directed bench for reg_wr_arbiter: reset, grants, rotation,
// hold freeze, pointer wrap and reset during a pending request.
module tb_reg_wr_arbiter;
  import reg_arb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  reg_wr_arbiter_if bus ();

  reg_wr_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int i, input logic v,
                         input logic [2:0] a,
                         input logic [15:0] d);
    bus.req_valid[i]        = v;
    bus.req_addr[i*3 +: 3]  = a;
    bus.req_data[i*16 +: 16] = d;
  endtask

  task automatic clear_all();
    bus.req_valid = '0;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    bus.hold = 1'b0;
    for (int i = 0; i < 4; i++)
      set_req(i, 1'b1, 3'(i + 1), 16'h1234);
    settle();
    tests++;
    if (bus.req_ready !== 4'b0000) begin
      fails++;
      $display("FAIL reset_ready got=%b exp=0000",
               bus.req_ready);
    end
    tick();
    tick();
    tests++;
    if (bus.wr_en !== 1'b0 || bus.wr_addr !== 3'd0 ||
        bus.wr_data !== 16'h0000 || bus.grant_idx !== 2'd0) begin
      fails++;
      $display("FAIL reset_regs got en=%b a=%0d d=%h g=%0d exp 0",
               bus.wr_en, bus.wr_addr, bus.wr_data, bus.grant_idx);
    end
    tests++;
    if (bus.req_ready !== 4'b0000) begin
      fails++;
      $display("FAIL reset_ready2 got=%b exp=0000",
               bus.req_ready);
    end
    clear_all();
    rst = 1'b0;
    tick();
    tests++;
    if (bus.wr_en !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle got=%b exp=0", bus.wr_en);
    end
  endtask

  task automatic test_single();
    set_req(1, 1'b1, 3'd5, 16'hBEEF);
    settle();
    tests++;
    if (bus.req_ready !== 4'b0010) begin
      fails++;
      $display("FAIL single_ready got=%b exp=0010",
               bus.req_ready);
    end
    tick();
    tests++;
    if (bus.wr_en !== 1'b1 || bus.wr_addr !== 3'd5 ||
        bus.wr_data !== 16'hBEEF || bus.grant_idx !== 2'd1) begin
      fails++;
      $display("FAIL single_write got en=%b a=%0d d=%h g=%0d exp 1/5/beef/1",
               bus.wr_en, bus.wr_addr, bus.wr_data, bus.grant_idx);
    end
    clear_all();
    tick();
    tests++;
    if (bus.wr_en !== 1'b0 || bus.wr_addr !== 3'd5 ||
        bus.wr_data !== 16'hBEEF) begin
      fails++;
      $display("FAIL single_idle got en=%b a=%0d d=%h exp 0/5/beef",
               bus.wr_en, bus.wr_addr, bus.wr_data);
    end
  endtask

  task automatic test_round_robin();
    int w;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++)
      set_req(i, 1'b1, 3'(i + 1), 16'hA000 | 16'(i));
    for (int k = 0; k < 5; k++) begin
      w = k % 4;
      settle();
      tests++;
      if (bus.req_ready !== 4'(1 << w)) begin
        fails++;
        $display("FAIL rr_ready[%0d] got=%b exp=%b",
                 k, bus.req_ready, 4'(1 << w));
      end
      tick();
      tests++;
      if (bus.wr_en !== 1'b1 || bus.grant_idx !== 2'(w) ||
          bus.wr_data !== (16'hA000 | 16'(w)) ||
          bus.wr_addr !== 3'(w + 1)) begin
        fails++;
        $display("FAIL rr_write[%0d] got en=%b g=%0d d=%h a=%0d exp g=%0d",
                 k, bus.wr_en, bus.grant_idx, bus.wr_data,
                 bus.wr_addr, w);
      end
    end
    clear_all();
    tick();
  endtask

  task automatic test_hold();
    set_req(2, 1'b1, 3'd6, 16'h2222);
    settle();
    tests++;
    if (bus.req_ready !== 4'b0100) begin
      fails++;
      $display("FAIL hold_pre_ready got=%b exp=0100",
               bus.req_ready);
    end
    tick();
    set_req(2, 1'b0, 3'd6, 16'h2222);
    set_req(0, 1'b1, 3'd1, 16'h0F0F);
    set_req(3, 1'b1, 3'd7, 16'h3333);
    bus.hold = 1'b1;
    settle();
    tests++;
    if (bus.req_ready !== 4'b0000) begin
      fails++;
      $display("FAIL hold_ready got=%b exp=0000",
               bus.req_ready);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      tests++;
      if (bus.wr_en !== 1'b1 || bus.wr_addr !== 3'd6 ||
          bus.wr_data !== 16'h2222 || bus.grant_idx !== 2'd2 ||
          bus.req_ready !== 4'b0000) begin
        fails++;
        $display("FAIL hold_frozen[%0d] got en=%b a=%0d d=%h g=%0d r=%b",
                 c, bus.wr_en, bus.wr_addr, bus.wr_data,
                 bus.grant_idx, bus.req_ready);
      end
    end
    bus.hold = 1'b0;
    settle();
    tests++;
    if (bus.req_ready !== 4'b1000) begin
      fails++;
      $display("FAIL hold_release_ready got=%b exp=1000",
               bus.req_ready);
    end
    tick();
    tests++;
    if (bus.grant_idx !== 2'd3 || bus.wr_data !== 16'h3333) begin
      fails++;
      $display("FAIL hold_release got g=%0d d=%h exp 3/3333",
               bus.grant_idx, bus.wr_data);
    end
    set_req(3, 1'b0, 3'd7, 16'h3333);
    settle();
    tests++;
    if (bus.req_ready !== 4'b0001) begin
      fails++;
      $display("FAIL hold_next_ready got=%b exp=0001",
               bus.req_ready);
    end
    tick();
    clear_all();
    tick();
  endtask

  task automatic test_wrap();
    set_req(2, 1'b1, 3'd2, 16'h0202);
    tick();
    set_req(2, 1'b0, 3'd2, 16'h0202);
    set_req(3, 1'b1, 3'd3, 16'h0303);
    set_req(0, 1'b1, 3'd4, 16'h0404);
    settle();
    tests++;
    if (bus.req_ready !== 4'b1000) begin
      fails++;
      $display("FAIL wrap_ready3 got=%b exp=1000",
               bus.req_ready);
    end
    tick();
    tests++;
    if (bus.grant_idx !== 2'd3 || bus.wr_data !== 16'h0303) begin
      fails++;
      $display("FAIL wrap_grant3 got g=%0d d=%h exp 3/0303",
               bus.grant_idx, bus.wr_data);
    end
    set_req(3, 1'b0, 3'd3, 16'h0303);
    settle();
    tests++;
    if (bus.req_ready !== 4'b0001) begin
      fails++;
      $display("FAIL wrap_ready0 got=%b exp=0001",
               bus.req_ready);
    end
    tick();
    tests++;
    if (bus.wr_en !== 1'b1 || bus.grant_idx !== 2'd0 ||
        bus.wr_addr !== 3'd4 || bus.wr_data !== 16'h0404) begin
      fails++;
      $display("FAIL wrap_grant0 got en=%b g=%0d a=%0d d=%h exp 1/0/4/0404",
               bus.wr_en, bus.grant_idx, bus.wr_addr, bus.wr_data);
    end
    clear_all();
    tick();
  endtask

  task automatic test_reset_mid();
    set_req(2, 1'b1, 3'd5, 16'h5A5A);
    settle();
    tests++;
    if (bus.req_ready !== 4'b0100) begin
      fails++;
      $display("FAIL rstmid_ready got=%b exp=0100",
               bus.req_ready);
    end
    rst = 1'b1;
    settle();
    tests++;
    if (bus.req_ready !== 4'b0000) begin
      fails++;
      $display("FAIL rstmid_ready_rst got=%b exp=0000",
               bus.req_ready);
    end
    tick();
    tests++;
    if (bus.wr_en !== 1'b0 || bus.grant_idx !== 2'd0 ||
        bus.wr_data !== 16'h0000) begin
      fails++;
      $display("FAIL rstmid_regs got en=%b g=%0d d=%h exp 0/0/0000",
               bus.wr_en, bus.grant_idx, bus.wr_data);
    end
    rst = 1'b0;
    settle();
    tests++;
    if (bus.req_ready !== 4'b0100) begin
      fails++;
      $display("FAIL rstmid_regrant_ready got=%b exp=0100",
               bus.req_ready);
    end
    tick();
    tests++;
    if (bus.wr_en !== 1'b1 || bus.grant_idx !== 2'd2 ||
        bus.wr_data !== 16'h5A5A) begin
      fails++;
      $display("FAIL rstmid_regrant got en=%b g=%0d d=%h exp 1/2/5a5a",
               bus.wr_en, bus.grant_idx, bus.wr_data);
    end
  endtask

  task automatic test_rst_hold();
    set_req(1, 1'b1, 3'd1, 16'h1111);
    rst = 1'b1;
    bus.hold = 1'b1;
    settle();
    tests++;
    if (bus.req_ready !== 4'b0000) begin
      fails++;
      $display("FAIL rsthold_ready got=%b exp=0000",
               bus.req_ready);
    end
    tick();
    tests++;
    if (bus.wr_en !== 1'b0 || bus.wr_data !== 16'h0000) begin
      fails++;
      $display("FAIL rsthold_regs got en=%b d=%h exp 0/0000",
               bus.wr_en, bus.wr_data);
    end
    rst = 1'b0;
    bus.hold = 1'b0;
    clear_all();
    tick();
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.hold      = 1'b0;
    rst           = 1'b1;
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_hold();
    test_wrap();
    test_reset_mid();
    test_rst_hold();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
